buzzer_sched: RTL and testbench

BUZZER_SCHED -- requirements
Module: buzzer_sched

---
 rtl/buzzer_sched.sv | 146 ++++++++++++++
 tb/tb_buzzer_sched.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/buzzer_sched.sv
// Buzzer pattern scheduler: latches 3 beep requests and plays
// 1..3 beeps of fixed on-time/gap for the highest pending source.
module buzzer_sched #(
  parameter int BEEP_ON_RLD           = 4_999_999,
  parameter int BEEP_ON_RLD_TURBOSIM  = 9,
  parameter int BEEP_GAP_RLD          = 4_999_999,
  parameter int BEEP_GAP_RLD_TURBOSIM = 9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       turbosim,
  input  logic [2:0] req,
  output logic       buzz_en,
  output logic       busy,
  output logic [2:0] grant,
  output logic [2:0] pending,
  output logic       done
);

  function automatic int wordlength(input longint v);
    int w;
    w = 1;
    for (int i = 1; i < 63; i++) begin
      if (v >= (longint'(1) << i)) w = i + 1;
    end
    return w;
  endfunction

  localparam int MAXR = (BEEP_ON_RLD > BEEP_GAP_RLD) ?
                        BEEP_ON_RLD : BEEP_GAP_RLD;
  localparam int TW = wordlength(longint'(MAXR));

  localparam logic [TW-1:0] ON_N  = TW'(BEEP_ON_RLD);
  localparam logic [TW-1:0] ON_T  = TW'(BEEP_ON_RLD_TURBOSIM);
  localparam logic [TW-1:0] GAP_N = TW'(BEEP_GAP_RLD);
  localparam logic [TW-1:0] GAP_T = TW'(BEEP_GAP_RLD_TURBOSIM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      beeps_q, beeps_d;
  logic [2:0]      pend_q, pend_d;
  logic [2:0]      grant_q, grant_d;
  logic            done_q, done_d;
  logic [2:0]      clr;
  logic [TW-1:0]   on_rld;
  logic [TW-1:0]   gap_rld;

  // Reload values are only consumed on a load, so a turbosim
  // change never disturbs a count already running.
  assign on_rld  = turbosim ? ON_T : ON_N;
  assign gap_rld = turbosim ? GAP_T : GAP_N;

  // Next-state, timer, grant and request bookkeeping
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    beeps_d = beeps_q;
    grant_d = grant_q;
    done_d  = 1'b0;
    clr     = 3'b000;
    unique case (state_q)
      IDLE: begin
        if (pend_q != 3'b000) begin
          state_d = ON;
          timer_d = on_rld;
          priority case (1'b1)
            pend_q[2]: begin
              grant_d = 3'b100;
              beeps_d = 2'd2;
              clr     = 3'b100;
            end
            pend_q[1]: begin
              grant_d = 3'b010;
              beeps_d = 2'd1;
              clr     = 3'b010;
            end
            default: begin
              grant_d = 3'b001;
              beeps_d = 2'd0;
              clr     = 3'b001;
            end
          endcase
        end
      end
      ON: begin
        if (timer_q == '0) begin
          state_d = GAP;
          timer_d = gap_rld;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      GAP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (beeps_q != 2'd0) begin
          state_d = ON;
          timer_d = on_rld;
          beeps_d = beeps_q - 1'b1;
        end else begin
          state_d = IDLE;
          grant_d = 3'b000;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
    endcase
    // A request on the granting edge wins over the clear.
    pend_d = (pend_q & ~clr) | req;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      beeps_q <= '0;
      pend_q  <= '0;
      grant_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      beeps_q <= beeps_d;
      pend_q  <= pend_d;
      grant_q <= grant_d;
      done_q  <= done_d;
    end
  end

  assign buzz_en = (state_q == ON);
  assign busy    = (state_q != IDLE);
  assign grant   = grant_q;
  assign pending = pend_q;
  assign done    = done_q;

endmodule

// File: tb/tb_buzzer_sched.sv
// Directed scoreboard bench for buzzer_sched in turbosim mode
// (10-cycle beeps, 10-cycle gaps).
module tb_buzzer_sched;

  logic       clk;
  logic       reset_n;
  logic       turbosim;
  logic [2:0] req;
  logic       buzz_en;
  logic       busy;
  logic [2:0] grant;
  logic [2:0] pending;
  logic       done;

  typedef struct packed {
    logic       buzz;
    logic       busy;
    logic [2:0] grant;
    logic [2:0] pend;
    logic       done;
  } exp_t;

  exp_t  q[$];
  int    errors = 0;
  int    checks = 0;
  string tag;

  buzzer_sched dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .turbosim (turbosim),
    .req      (req),
    .buzz_en  (buzz_en),
    .busy     (busy),
    .grant    (grant),
    .pending  (pending),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t observed();
    exp_t o;
    o.buzz  = buzz_en;
    o.busy  = busy;
    o.grant = grant;
    o.pend  = pending;
    o.done  = done;
    return o;
  endfunction

  task automatic check(input exp_t e);
    exp_t o;
    o = observed();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%b expected=%b",
             tag, $time, o, e);
    end
  endtask

  task automatic push(input logic b, input logic bs,
                      input logic [2:0] g, input logic [2:0] p,
                      input logic d);
    exp_t e;
    e.buzz  = b;
    e.busy  = bs;
    e.grant = g;
    e.pend  = p;
    e.done  = d;
    q.push_back(e);
  endtask

  // n beeps of source g, then the done cycle; p0 is pending
  // in the very first ON cycle, p everywhere after.
  task automatic push_pat(input logic [2:0] g, input int n,
                          input logic [2:0] p0,
                          input logic [2:0] p);
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < 10; c++)
        push(1'b1, 1'b1, g, (b == 0 && c == 0) ? p0 : p, 1'b0);
      for (int c = 0; c < 10; c++)
        push(1'b0, 1'b1, g, p, 1'b0);
    end
    push(1'b0, 1'b0, 3'b000, p, 1'b1);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    e = q.pop_front();
    check(e);
  endtask

  task automatic drain();
    while (q.size() != 0) tick();
  endtask

  initial begin
    exp_t zero;
    zero     = '0;
    turbosim = 1'b1;
    req      = 3'b111;
    reset_n  = 1'b0;

    tag = "reset_async";
    #1;
    check(zero);
    tag = "reset_hold";
    for (int i = 0; i < 3; i++) push(0, 0, 3'b000, 3'b000, 0);
    drain();
    req     = 3'b000;
    reset_n = 1'b1;
    tag = "post_reset_idle";
    for (int i = 0; i < 2; i++) push(0, 0, 3'b000, 3'b000, 0);
    drain();

    tag = "pulse_001";
    req = 3'b001;
    push(0, 0, 3'b000, 3'b001, 0);
    tick();
    req = 3'b000;
    push_pat(3'b001, 1, 3'b000, 3'b000);
    push(0, 0, 3'b000, 3'b000, 0);
    push(0, 0, 3'b000, 3'b000, 0);
    drain();

    tag = "pulse_100";
    req = 3'b100;
    push(0, 0, 3'b000, 3'b100, 0);
    tick();
    req = 3'b000;
    push_pat(3'b100, 3, 3'b000, 3'b000);
    push(0, 0, 3'b000, 3'b000, 0);
    drain();

    tag = "prio_101";
    req = 3'b101;
    push(0, 0, 3'b000, 3'b101, 0);
    tick();
    req = 3'b000;
    push_pat(3'b100, 3, 3'b001, 3'b001);
    push_pat(3'b001, 1, 3'b000, 3'b000);
    push(0, 0, 3'b000, 3'b000, 0);
    drain();

    tag = "merge_retrigger_010";
    req = 3'b010;
    push(0, 0, 3'b000, 3'b010, 0);
    tick();
    req = 3'b000;
    push_pat(3'b010, 2, 3'b000, 3'b010);
    push_pat(3'b010, 2, 3'b000, 3'b000);
    push(0, 0, 3'b000, 3'b000, 0);
    tick();
    req = 3'b010;
    tick();
    req = 3'b000;
    drain();

    tag = "set_wins_on_grant";
    req = 3'b001;
    push(0, 0, 3'b000, 3'b001, 0);
    tick();
    push_pat(3'b001, 1, 3'b001, 3'b001);
    push_pat(3'b001, 1, 3'b000, 3'b000);
    push(0, 0, 3'b000, 3'b000, 0);
    tick();
    req = 3'b000;
    drain();

    tag = "reset_mid_beep";
    req = 3'b001;
    push(0, 0, 3'b000, 3'b001, 0);
    tick();
    req = 3'b000;
    for (int i = 0; i < 5; i++) push(1, 1, 3'b001, 3'b000, 0);
    drain();
    #2;
    reset_n = 1'b0;
    #1;
    tag = "reset_mid_beep_async";
    check(zero);
    tag = "reset_mid_beep_hold";
    for (int i = 0; i < 2; i++) push(0, 0, 3'b000, 3'b000, 0);
    drain();
    reset_n = 1'b1;
    tag = "reset_mid_beep_idle";
    for (int i = 0; i < 5; i++) push(0, 0, 3'b000, 3'b000, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
